cu_seq: RTL and testbench

Single-clock, parametrised multi-cycle control sequencer for the CPU datapath. It replaces the five external phase clocks with an internal state machine (IF, ID, EX, MEM, WB, HALT) and skips phases an instruction does not need. It also adds instruction- and data-memory wait handshakes, an optional data-memory timeout fault, resume from halt, and a retired-instruction counter. It sits between the instruction register, the register file, the ALU, the data memory and the write-back mux.

---
 rtl/cu_pkg.sv | 50 +++++
 rtl/cu_decode.sv | 48 ++++
 rtl/cu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_cu_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_pkg
// Purpose  : Shared opcodes, state encoding and output codes for the
//            cu_seq control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cu_pkg;

   // Instruction opcodes (low 6 bits of the opcode field)
   localparam logic [5:0] OP_HLT = 6'h00;
   localparam logic [5:0] OP_LDI = 6'h10;
   localparam logic [5:0] OP_LUI = 6'h11;
   localparam logic [5:0] OP_LW  = 6'h18;
   localparam logic [5:0] OP_SW  = 6'h19;
   localparam logic [5:0] OP_LB  = 6'h1A;
   localparam logic [5:0] OP_SB  = 6'h1B;
   localparam logic [5:0] OP_JMP = 6'h1C;
   localparam logic [5:0] OP_JR  = 6'h1D;
   localparam logic [5:0] OP_BEQ = 6'h1E;
   localparam logic [5:0] OP_BLT = 6'h1F;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_t;

   // ALU operations forced by the sequencer
   localparam logic [4:0] ALU_SUB  = 5'b00010;
   localparam logic [4:0] ALU_SLT  = 5'b01111;
   localparam logic [4:0] ALU_ADDI = 5'b10010;

   // Write-back mux selects
   localparam logic [1:0] MUX_NONE = 2'b00;
   localparam logic [1:0] MUX_MEM  = 2'b01;
   localparam logic [1:0] MUX_ALU  = 2'b10;
   localparam logic [1:0] MUX_IMM  = 2'b11;

   // Data-memory access sizes
   localparam logic [1:0] MEM_IDLE = 2'b00;
   localparam logic [1:0] MEM_BYTE = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b11;

endpackage : cu_pkg
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// ============================================================================
// Module   : cu_decode
// Purpose  : Combinational instruction classifier. Any opcode that is not one
//            of the named encodings (including nonzero upper bits) is ALU class.
// Revision : 1.0 - initial release
// ============================================================================
module cu_decode
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 6
) (
   input  logic [OPCODE_W-1:0] op_i,
   output logic                is_hlt_o,
   output logic                is_imm_o,
   output logic                is_branch_o,
   output logic                is_load_o,
   output logic                is_store_o,
   output logic                is_byte_o,
   output logic                is_alu_o
);

   logic       w_hi_zero;
   logic [5:0] w_low;

   assign w_low = op_i[5:0];

   generate
      if (OPCODE_W > 6) begin : g_hi_bits
         assign w_hi_zero = ~|op_i[OPCODE_W-1:6];
      end else begin : g_no_hi_bits
         assign w_hi_zero = 1'b1;
      end
   endgenerate

   // Classify the opcode; only exact encodings with clear upper bits are special
   always_comb begin
      is_hlt_o    = w_hi_zero && (w_low == OP_HLT);
      is_imm_o    = w_hi_zero && ((w_low == OP_LDI) || (w_low == OP_LUI));
      is_branch_o = w_hi_zero && (w_low[5:2] == OP_JMP[5:2]);
      is_load_o   = w_hi_zero && ((w_low == OP_LW) || (w_low == OP_LB));
      is_store_o  = w_hi_zero && ((w_low == OP_SW) || (w_low == OP_SB));
      is_byte_o   = w_hi_zero && ((w_low == OP_LB) || (w_low == OP_SB));
      is_alu_o    = !(is_hlt_o || is_imm_o || is_branch_o || is_load_o || is_store_o);
   end

endmodule : cu_decode
`default_nettype wire

// File: rtl/cu_seq.sv
`default_nettype none
// ============================================================================
// Module   : cu_seq
// Purpose  : Single-clock multi-cycle control sequencer (IF/ID/EX/MEM/WB/HALT)
//            with memory wait handshakes, optional data-memory timeout fault,
//            resume from halt and a saturating retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module cu_seq
   import cu_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALU_OP_W    = 5,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                imem_ready,
   input  logic                dmem_ack,
   input  logic                resume,
   output logic [5:0]          phase,
   output logic                ir_load,
   output logic                halt,
   output logic                fault,
   output logic                reg_read,
   output logic                reg_write,
   output logic                alu_enable,
   output logic [ALU_OP_W-1:0] alu_opcode,
   output logic [2:0]          branch_opcode,
   output logic [1:0]          mem_read,
   output logic [1:0]          mem_write,
   output logic [1:0]          mux_opcode,
   output logic [CNT_W-1:0]    retired
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q;
   logic [CNT_W-1:0]    retired_q, retired_d;
   logic                fault_q, fault_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                w_retire;
   logic                w_timeout;

   logic [OPCODE_W-1:0] w_dec_op;
   logic w_is_hlt, w_is_imm, w_is_branch, w_is_load, w_is_store, w_is_byte, w_is_alu;

   // op_q is only captured at the end of ID, so decisions made in ID must
   // classify the live opcode; every later state uses the captured copy.
   assign w_dec_op = (state_q == ST_ID) ? opcode : op_q;

   cu_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .op_i        (w_dec_op),
      .is_hlt_o    (w_is_hlt),
      .is_imm_o    (w_is_imm),
      .is_branch_o (w_is_branch),
      .is_load_o   (w_is_load),
      .is_store_o  (w_is_store),
      .is_byte_o   (w_is_byte),
      .is_alu_o    (w_is_alu)
   );

   // Last MEM cycle allowed without an ack; dmem_ack still takes priority
   assign w_timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   // State and datapath-control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IF;
         op_q      <= '0;
         retired_q <= '0;
         fault_q   <= 1'b0;
         wait_q    <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         fault_q   <= fault_d;
         wait_q    <= wait_d;
         if (state_q == ST_ID) begin
            op_q <= opcode;
         end
      end
   end

   // Next-state, wait-counter, fault and retire-count logic
   always_comb begin
      state_d  = state_q;
      fault_d  = fault_q;
      wait_d   = '0;
      w_retire = 1'b0;
      case (state_q)
         ST_IF: begin
            if (imem_ready) state_d = ST_ID;
         end
         ST_ID: begin
            if (w_is_hlt)      state_d = ST_HALT;
            else if (w_is_imm) state_d = ST_WB;
            else               state_d = ST_EX;
         end
         ST_EX: begin
            if (w_is_branch) begin
               state_d  = ST_IF;
               w_retire = 1'b1;
            end else if (w_is_load || w_is_store) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (dmem_ack) begin
               if (w_is_load) begin
                  state_d = ST_WB;
               end else begin
                  state_d  = ST_IF;
                  w_retire = 1'b1;
               end
            end else if (w_timeout) begin
               state_d = ST_HALT;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_WB: begin
            state_d  = ST_IF;
            w_retire = 1'b1;
         end
         ST_HALT: begin
            if (resume && !fault_q) state_d = ST_IF;
         end
         default: state_d = ST_IF;
      endcase

      retired_d = retired_q;
      if (w_retire && (retired_q != {CNT_W{1'b1}})) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   // Moore outputs decoded from the current state and instruction class
   always_comb begin
      phase         = 6'b000000;
      ir_load       = 1'b0;
      halt          = 1'b0;
      reg_read      = 1'b0;
      reg_write     = 1'b0;
      alu_enable    = 1'b0;
      alu_opcode    = '0;
      branch_opcode = 3'b000;
      mem_read      = MEM_IDLE;
      mem_write     = MEM_IDLE;
      mux_opcode    = MUX_NONE;
      case (state_q)
         ST_IF: begin
            phase   = 6'b000001;
            ir_load = imem_ready;
         end
         ST_ID: begin
            phase    = 6'b000010;
            reg_read = !w_is_hlt;
         end
         ST_EX: begin
            phase = 6'b000100;
            // JMP and JR (op[1]=0 within the branch group) need no ALU
            alu_enable = !(w_is_branch && !op_q[1]);
            if (w_is_branch) begin
               branch_opcode = {1'b1, op_q[1:0]};
               if (op_q[5:0] == OP_BEQ)      alu_opcode = ALU_OP_W'(ALU_SUB);
               else if (op_q[5:0] == OP_BLT) alu_opcode = ALU_OP_W'(ALU_SLT);
            end else if (w_is_load || w_is_store) begin
               alu_opcode = ALU_OP_W'(ALU_ADDI);
            end else if (w_is_alu) begin
               alu_opcode = ALU_OP_W'(op_q[4:0]);
            end
         end
         ST_MEM: begin
            phase = 6'b001000;
            if (w_is_load)  mem_read  = w_is_byte ? MEM_BYTE : MEM_WORD;
            if (w_is_store) mem_write = w_is_byte ? MEM_BYTE : MEM_WORD;
         end
         ST_WB: begin
            phase     = 6'b010000;
            reg_write = 1'b1;
            if (w_is_load)     mux_opcode = MUX_MEM;
            else if (w_is_imm) mux_opcode = MUX_IMM;
            else if (w_is_alu) mux_opcode = MUX_ALU;
         end
         ST_HALT: begin
            phase = 6'b100000;
            halt  = 1'b1;
         end
         default: phase = 6'b000000;
      endcase
   end

   assign fault   = fault_q;
   assign retired = retired_q;

endmodule : cu_seq
`default_nettype wire

// File: tb/tb_cu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_seq
// Purpose  : Directed self-checking bench for cu_seq (MEM_TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic        imem_ready;
   logic        dmem_ack;
   logic        resume;
   logic [5:0]  phase;
   logic        ir_load;
   logic        halt;
   logic        fault;
   logic        reg_read;
   logic        reg_write;
   logic        alu_enable;
   logic [4:0]  alu_opcode;
   logic [2:0]  branch_opcode;
   logic [1:0]  mem_read;
   logic [1:0]  mem_write;
   logic [1:0]  mux_opcode;
   logic [31:0] retired;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cu_seq #(
      .OPCODE_W    (6),
      .ALU_OP_W    (5),
      .CNT_W       (32),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .imem_ready    (imem_ready),
      .dmem_ack      (dmem_ack),
      .resume        (resume),
      .phase         (phase),
      .ir_load       (ir_load),
      .halt          (halt),
      .fault         (fault),
      .reg_read      (reg_read),
      .reg_write     (reg_write),
      .alu_enable    (alu_enable),
      .alu_opcode    (alu_opcode),
      .branch_opcode (branch_opcode),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mux_opcode    (mux_opcode),
      .retired       (retired)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // All outputs other than phase, ir_load and retired, packed together
   function automatic logic [19:0] others();
      return {halt, fault, reg_read, reg_write, alu_enable, alu_opcode,
              branch_opcode, mem_read, mem_write, mux_opcode};
   endfunction

   initial begin
      rst = 1'b1; opcode = 6'h00; imem_ready = 1'b0; dmem_ack = 1'b0; resume = 1'b0;
      tick(); tick();
      chk("rst_phase", phase, 6'b000001);
      chk("rst_irload0", ir_load, 1'b0);
      chk("rst_others", others(), 20'h0);
      chk("rst_retired", retired, 32'd0);
      imem_ready = 1'b1; #1;
      chk("rst_irload1", ir_load, 1'b1);
      rst = 1'b0;

      // LW with two memory wait cycles
      opcode = 6'h18;
      tick(); chk("lw_id", phase, 6'b000010); chk("lw_regread", reg_read, 1'b1);
      tick(); chk("lw_ex", phase, 6'b000100); chk("lw_aluop", alu_opcode, 5'b10010);
      chk("lw_aluen", alu_enable, 1'b1);
      tick(); chk("lw_mem0", phase, 6'b001000); chk("lw_rd0", mem_read, 2'b11);
      tick(); chk("lw_mem1", phase, 6'b001000); chk("lw_rd1", mem_read, 2'b11);
      tick(); chk("lw_mem2", phase, 6'b001000); chk("lw_rd2", mem_read, 2'b11);
      dmem_ack = 1'b1;
      tick(); dmem_ack = 1'b0;
      chk("lw_wb", phase, 6'b010000); chk("lw_mux", mux_opcode, 2'b01);
      chk("lw_regwr", reg_write, 1'b1); chk("lw_ret_wb", retired, 32'd0);
      tick(); chk("lw_if", phase, 6'b000001); chk("lw_ret", retired, 32'd1);

      // BEQ
      opcode = 6'h1E;
      tick(); chk("beq_id", phase, 6'b000010); chk("beq_nowr_id", reg_write, 1'b0);
      tick(); chk("beq_ex", phase, 6'b000100); chk("beq_aluop", alu_opcode, 5'b00010);
      chk("beq_br", branch_opcode, 3'b110); chk("beq_nowr_ex", reg_write, 1'b0);
      tick(); chk("beq_if", phase, 6'b000001); chk("beq_ret", retired, 32'd2);

      // SB acked in its first MEM cycle
      opcode = 6'h1B;
      tick(); tick(); chk("sb_ex", phase, 6'b000100);
      tick(); chk("sb_mem", phase, 6'b001000); chk("sb_wr", mem_write, 2'b01);
      chk("sb_rd", mem_read, 2'b00);
      dmem_ack = 1'b1;
      tick(); dmem_ack = 1'b0;
      chk("sb_if", phase, 6'b000001); chk("sb_ret", retired, 32'd3);
      chk("sb_wr_idle", mem_write, 2'b00);

      // JMP: no ALU, branch code 100
      opcode = 6'h1C;
      tick(); tick(); chk("jmp_ex", phase, 6'b000100);
      chk("jmp_aluen", alu_enable, 1'b0); chk("jmp_br", branch_opcode, 3'b100);
      chk("jmp_aluop", alu_opcode, 5'b00000);
      tick(); chk("jmp_if", phase, 6'b000001); chk("jmp_ret", retired, 32'd4);

      // LW with no ack: timeout after four MEM cycles
      opcode = 6'h18;
      tick(); tick(); tick();
      chk("to_mem0", phase, 6'b001000);
      tick(); tick(); tick();
      chk("to_mem3", phase, 6'b001000);
      tick();
      chk("to_halt", phase, 6'b100000); chk("to_haltsig", halt, 1'b1);
      chk("to_fault", fault, 1'b1); chk("to_ret", retired, 32'd4);
      resume = 1'b1;
      tick(); resume = 1'b0;
      chk("to_resume_ign", phase, 6'b100000); chk("to_fault_sticky", fault, 1'b1);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("to_rst_phase", phase, 6'b000001); chk("to_rst_fault", fault, 1'b0);
      chk("to_rst_ret", retired, 32'd0);

      // HLT, with resume already high during ID (must not skip HALT)
      opcode = 6'h00;
      tick(); chk("hlt_id", phase, 6'b000010); chk("hlt_noread", reg_read, 1'b0);
      resume = 1'b1;
      tick(); chk("hlt_halt", phase, 6'b100000); chk("hlt_fault", fault, 1'b0);
      tick(); resume = 1'b0;
      chk("hlt_resume", phase, 6'b000001); chk("hlt_ret", retired, 32'd0);

      // Fetch stall
      imem_ready = 1'b0; #1;
      chk("stall_irload", ir_load, 1'b0);
      tick(); chk("stall_if", phase, 6'b000001);
      imem_ready = 1'b1;

      // ADDI-class op (08) aborted by reset in WB
      opcode = 6'h08;
      tick(); tick(); chk("addi_aluop", alu_opcode, 5'b01000);
      tick(); chk("addi_wb", phase, 6'b010000); chk("addi_mux", mux_opcode, 2'b10);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("addi_rst_phase", phase, 6'b000001); chk("addi_rst_irload", ir_load, 1'b1);
      chk("addi_rst_others", others(), 20'h0); chk("addi_rst_ret", retired, 32'd0);

      // LDI: IF, ID, WB
      opcode = 6'h10;
      tick(); tick(); chk("ldi_wb", phase, 6'b010000); chk("ldi_mux", mux_opcode, 2'b11);
      tick(); chk("ldi_if", phase, 6'b000001); chk("ldi_ret", retired, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_cu_seq
`default_nettype wire
